// File: rtl/ma_pkg.sv
// Shared widths and bounds for the moving-average filter pair.
// Defaults (WL, LOG2N) plus helpers that derive N, depth, sum and pointer widths.
package ma_pkg;

    localparam int MA_WL    = 32;
    localparam int MA_LOG2N = 2;

    function automatic int ma_n(input int log2n);
        return 1 << log2n;
    endfunction

    function automatic int ma_depth(input int log2n);
        return (1 << log2n) - 1;
    endfunction

    function automatic int ma_sum_w(input int wl, input int log2n);
        return wl + log2n;
    endfunction

    function automatic int ma_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic longint ma_sat_max(input int wl);
        return (64'sd1 <<< (wl - 1)) - 64'sd1;
    endfunction

    function automatic longint ma_sat_min(input int wl);
        return -(64'sd1 <<< (wl - 1));
    endfunction

endpackage

// File: rtl/ma_inv_history.sv
// Ring buffer of the last DEPTH reconstructed samples, with write pointer and fill count.
// Ports: clk, rst (sync high), clr, we, wdata -> old (entry about to be overwritten), primed.
module ma_inv_history
    import ma_pkg::*;
#(
    parameter int WL    = MA_WL,
    parameter int DEPTH = ma_depth(MA_LOG2N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          we,
    input  logic [WL-1:0] wdata,
    output logic [WL-1:0] old,
    output logic          primed
);

    localparam int PTR_W = ma_ptr_w(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WL-1:0]    mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [CNT_W-1:0] cnt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A clear in the same cycle makes the history look empty to the datapath.
    assign old    = clr ? '0 : mem[wptr];
    assign primed = (cnt == CNT_W'(DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wptr <= '0;
            cnt  <= '0;
        end else if (we && clr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            mem[0] <= wdata;
            wptr   <= ptr_inc('0);
            cnt    <= CNT_W'(1);
        end else if (we) begin
            mem[wptr] <= wdata;
            wptr      <= ptr_inc(wptr);
            if (cnt != CNT_W'(DEPTH)) cnt <= cnt + 1'b1;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wptr <= '0;
            cnt  <= '0;
        end
    end

endmodule

// File: rtl/moving_average_inverse.sv
// Inverse N-tap moving average: x = (y << LOG2N) - sum of the previous N-1 outputs.
// Ports: CLK, RST (sync high), EN, CLR, data_in -> data_out, valid_out, primed. Macro: MA_INV_SAT_EN.
module moving_average_inverse
    import ma_pkg::*;
#(
    parameter int WL    = MA_WL,
    parameter int LOG2N = MA_LOG2N
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          EN,
    input  logic          CLR,
    input  logic [WL-1:0] data_in,
    output logic [WL-1:0] data_out,
    output logic          valid_out,
    output logic          primed
);

    localparam int DEPTH = ma_depth(LOG2N);
    localparam int SUM_W = ma_sum_w(WL, LOG2N);
    localparam int XW    = SUM_W + 1;

    logic signed [SUM_W-1:0] s_q;
    logic signed [SUM_W-1:0] s_eff;
    logic signed [SUM_W-1:0] s_next;
    logic signed [XW-1:0]    p;
    logic signed [XW-1:0]    x_full;
    logic [WL-1:0]           x_red;
    logic [WL-1:0]           old;

    always_comb begin
        p      = {{(XW-WL){data_in[WL-1]}}, data_in} << LOG2N;
        s_eff  = CLR ? '0 : s_q;
        x_full = p - {s_eff[SUM_W-1], s_eff};
    end

`ifdef MA_INV_SAT_EN
    localparam logic signed [XW-1:0] X_MAX = XW'(ma_sat_max(WL));
    localparam logic signed [XW-1:0] X_MIN = XW'(ma_sat_min(WL));

    always_comb begin
        x_red = x_full[WL-1:0];
        if (x_full > X_MAX) x_red = X_MAX[WL-1:0];
        else if (x_full < X_MIN) x_red = X_MIN[WL-1:0];
    end
`else
    // Two's-complement wrap: the upper bits are simply dropped.
    logic unused_hi;
    assign unused_hi = ^x_full[XW-1:WL];
    assign x_red     = x_full[WL-1:0];
`endif

    // The sum tracks the history exactly: add the new entry, drop the evicted one.
    assign s_next = s_eff
                  + {{LOG2N{x_red[WL-1]}}, x_red}
                  - {{LOG2N{old[WL-1]}}, old};

    always_ff @(posedge CLK) begin
        if (RST) begin
            data_out  <= '0;
            valid_out <= 1'b0;
            s_q       <= '0;
        end else begin
            valid_out <= EN;
            if (EN) begin
                data_out <= x_red;
                s_q      <= s_next;
            end else if (CLR) begin
                s_q <= '0;
            end
        end
    end

    ma_inv_history #(
        .WL    (WL),
        .DEPTH (DEPTH)
    ) u_hist (
        .clk    (CLK),
        .rst    (RST),
        .clr    (CLR),
        .we     (EN),
        .wdata  (x_red),
        .old    (old),
        .primed (primed)
    );

endmodule

// File: doc/moving_average_inverse.md
Name: moving_average_inverse

Overview:
- Reconstructs the original sample stream from the output of the team's N-tap moving-average filter.
- Sits at the far end of the averaging path; used for loopback checking and de-smoothing.
- Forward model: y[n] = (x[n] + ... + x[n-N+1]) >>> LOG2N, with zero-filled history after reset.
- Inverse: x[n] = (y[n] << LOG2N) - (x[n-1] + ... + x[n-N+1]), computed recursively from its own past outputs.

Parameters:
- WL, 32: sample word length, signed two's complement.
- LOG2N, 2: log2 of window length N (N = 4). Legal range 1..6.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- EN  in  1  sample strobe; data_in is consumed on a rising edge when EN=1.
- CLR  in  1  synchronous history clear, no output effect.
- data_in  in  WL  signed averaged sample.
- data_out  out  WL  signed reconstructed sample.
- valid_out  out  1  data_out updated this cycle.
- primed  out  1  at least N-1 samples accepted since last RST/CLR.

Behaviour:
- Reset (RST=1 at edge):
  - data_out=0, valid_out=0, primed=0.
  - History of N-1 entries = 0; running sum S = 0; write pointer = 0; fill counter = 0.
  - RST overrides CLR and EN.
- Latency is 1 cycle. EN=1 at edge k gives data_out/valid_out=1 after edge k. valid_out is a single-cycle pulse per accepted sample.
- EN=0 at an edge: valid_out=0; data_out, history, S and counters hold.
- Arithmetic:
  - P = sext(data_in) << LOG2N at WL+LOG2N+1 bits.
  - S is held at WL+LOG2N bits.
  - x = P - S, reduced to WL bits per the Optional Feature.
  - data_out = reduced x.
- History update on acceptance:
  - Reduced x is written at wptr, overwriting the oldest entry x_old.
  - S <= S + x - x_old.
  - wptr increments modulo N-1 and wraps (N=2: depth 1, wptr stays 0).
- primed: fill counter saturates at N-1; primed=1 once the counter equals N-1.
- CLR=1, EN=0: history, S, wptr and counter are zeroed; primed=0. data_out holds; valid_out=0.
- CLR=1 with EN=1 in the same cycle:
  - History is cleared first, then the sample is processed against empty history: data_out = reduced P, written to entry 0.
  - Counter becomes 1, and S is set to reduced P.
- Back-to-back EN every cycle is supported: full throughput, no stalls.
- Reset mid-stream discards all history. The next sample is treated as the first.

Optional Feature:
- Macro: MA_INV_SAT_EN.
- Defined: x outside [-2^(WL-1), 2^(WL-1)-1] saturates to the nearest bound; the saturated value enters the history.
- Undefined: x is truncated to its low WL bits (two's-complement wrap).

Decomposition:
- Shared package ma_pkg, common with the forward filter:
  - WL and LOG2N defaults.
  - Derived widths: N, HIST_DEPTH = N-1, SUM_W = WL+LOG2N, PTR_W.
  - Saturation bound constants.
- One sub-module: ma_inv_history.
  - Ring buffer of HIST_DEPTH WL-bit entries.
  - Write pointer and fill counter.
  - Oldest-entry read, clear.
- The top level holds the multiply-by-shift, S accumulator, reduce/saturate logic and output registers.

Test Plan:
- Basic reconstruction: WL=32, LOG2N=2, RST 2 cycles, then EN with data_in 1,3,6,10,14,18 -> data_out 4,8,12,16,20,24; valid_out pulses each cycle; primed=1 from the 3rd output onward.
- EN gaps: same stream with EN=0 for 3 cycles between the 2nd and 3rd samples -> data_out holds 8 through the gap with valid_out=0; outputs are still 4,8,12,16.
- CLR with EN: after the stream above, CLR=1 and EN=1 with data_in=5 -> data_out=20, primed=0; next data_in=5 -> data_out=0.
- Reset mid-stream: RST after the 2nd sample, then data_in=2 -> data_out=8, with no influence from prior history.
- Overflow, WL=8, LOG2N=2, data_in=100:
  - MA_INV_SAT_EN defined -> data_out=127.
  - Undefined -> data_out=-112.
- Negative values: data_in -1,-3 -> data_out -4,-8; S tracks -12 after the 2nd sample.
